// File: rtl/booth_pkg.sv
// Shared width helpers and FSM encodings for the radix-4 Booth partial-product stream.
package booth_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic int ndig(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int idx_w(input int w);
    return $clog2(ndig(w));
  endfunction

  function automatic int pp_w(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth digit decode and multiple selection for one triplet of the multiplier.
module booth_r4_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]               trip,
  input  logic [pp_w(WIDTH)-1:0]   x_ext,
  output logic                     sign,
  output logic                     one,
  output logic                     two,
  output logic [pp_w(WIDTH)-1:0]   pp,
  output logic                     carry
);

  localparam int PP_W = pp_w(WIDTH);

  logic [PP_W-1:0] m;

  always_comb begin
    sign  = trip[2];
    one   = trip[1] ^ trip[0];
    two   = (trip == 3'b100) || (trip == 3'b011);
    m     = one ? x_ext : {x_ext[PP_W-2:0], 1'b0};
    pp    = '0;
    carry = 1'b0;
    // A zero digit yields a true zero even when sign is set (triplet 111).
    if (one || two) begin
      pp    = sign ? ~m : m;
      carry = sign;
    end
  end

endmodule

// File: rtl/booth_r4_pp_stream.sv
// Sequential radix-4 Booth partial-product generator: one operand pair in, NDIG partial products out.
module booth_r4_pp_stream
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_signed,
  input  logic [WIDTH-1:0]          in_x,
  input  logic [WIDTH-1:0]          in_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [pp_w(WIDTH)-1:0]    out_pp,
  output logic                      out_carry,
  output logic                      out_sign,
  output logic                      out_one,
  output logic                      out_two,
  output logic [idx_w(WIDTH)-1:0]   out_idx,
  output logic                      out_last
);

  localparam int PP_W  = pp_w(WIDTH);
  localparam int NDIG  = ndig(WIDTH);
  localparam int IDX_W = idx_w(WIDTH);
  localparam int YE_W  = WIDTH + 3;

  logic [0:0]       state;
  logic [PP_W-1:0]  x_ext;
  logic [YE_W-1:0]  y_win;
  logic [IDX_W-1:0] idx;
  logic             busy;
  logic             last;

  logic             s_sign;
  logic             s_one;
  logic             s_two;
  logic [PP_W-1:0]  s_pp;
  logic             s_carry;

  assign busy = (state == ST_BUSY);
  assign last = (idx == IDX_W'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      x_ext <= '0;
      y_win <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state <= ST_BUSY;
            idx   <= '0;
            x_ext <= in_signed ? {{2{in_x[WIDTH-1]}}, in_x} : {2'b00, in_x};
            y_win <= {{2{in_signed & in_y[WIDTH-1]}}, in_y, 1'b0};
          end
        end
        ST_BUSY: begin
          if (out_ready) begin
            // Arithmetic shift keeps the extension bits valid for the top triplet.
            y_win <= {{2{y_win[YE_W-1]}}, y_win[YE_W-1:2]};
            if (last) begin
              state <= ST_IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  booth_r4_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .trip  (y_win[2:0]),
    .x_ext (x_ext),
    .sign  (s_sign),
    .one   (s_one),
    .two   (s_two),
    .pp    (s_pp),
    .carry (s_carry)
  );

  assign in_ready  = !busy;
  assign out_valid = busy;
  assign out_pp    = busy ? s_pp : '0;
  assign out_carry = busy & s_carry;
  assign out_sign  = busy & s_sign;
  assign out_one   = busy & s_one;
  assign out_two   = busy & s_two;
  assign out_idx   = busy ? idx : '0;
  assign out_last  = busy & last;

endmodule

// File: tb/tb_booth_r4_pp_stream.sv
// Randomised self-checking bench for booth_r4_pp_stream against an arithmetic Booth-digit model.
module tb_booth_r4_pp_stream;

  localparam int WIDTH = 32;
  localparam int PP_W  = 34;
  localparam int NDIG  = 17;
  localparam int IDX_W = 5;
  localparam int NRAND = 1500;
  localparam logic [31:0] XD = 32'h0000110F;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_signed;
  logic [WIDTH-1:0]  in_x;
  logic [WIDTH-1:0]  in_y;
  logic              out_valid;
  logic              out_ready;
  logic [PP_W-1:0]   out_pp;
  logic              out_carry;
  logic              out_sign;
  logic              out_one;
  logic              out_two;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
  } op_t;

  op_t         op_q[$];
  int          total = 0;
  int          bad = 0;
  int          beat = 0;
  logic [63:0] acc = '0;
  bit          held = 0;
  logic [43:0] saved;
  bit          rnd_stop = 0;

  always #5 clk = ~clk;

  booth_r4_pp_stream #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pp    (out_pp),
    .out_carry (out_carry),
    .out_sign  (out_sign),
    .out_one   (out_one),
    .out_two   (out_two),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout %s: got no response expected progress", name);
  endtask

  // Digit i of y is -2*t2 + t1 + t0 over the extended multiplier; pp + carry must equal digit*x.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                input int i, output logic [33:0] pp, output logic c,
                                output logic sg, output logic o, output logic tw);
    logic [34:0] ye;
    logic [2:0]  t;
    longint      d;
    longint      xv;
    longint      p;
    ye = {(s ? {2{y[31]}} : 2'b00), y, 1'b0};
    t  = ye[2*i +: 3];
    d  = longint'(t[1]) + longint'(t[0]) - 2 * longint'(t[2]);
    xv = s ? longint'($signed(x)) : longint'(x);
    p  = d * xv;
    sg = t[2];
    o  = (d == 1) || (d == -1);
    tw = (d == 2) || (d == -2);
    if (d == 0) begin
      pp = '0;
      c  = 1'b0;
    end else if (d < 0) begin
      pp = 34'(p - 1);
      c  = 1'b1;
    end else begin
      pp = 34'(p);
      c  = 1'b0;
    end
  endfunction

  function automatic logic [63:0] prod(input op_t op);
    if (op.s) return longint'($signed(op.x)) * longint'($signed(op.y));
    return {32'b0, op.x} * {32'b0, op.y};
  endfunction

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) op_q.push_back('{in_x, in_y, in_signed});
  end

  always @(negedge clk) begin : compare
    logic [33:0] epp;
    logic        ec, es, eo, et;
    logic [43:0] ovec;
    op_t         op;
    ovec = {out_pp, out_carry, out_sign, out_one, out_two, out_idx, out_last};
    if (!rst_n) begin
      op_q.delete();
      beat = 0;
      acc  = '0;
      held = 0;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_outs", ovec, 0);
    end else begin
      chk("in_ready", in_ready, op_q.size() == 0);
      chk("out_valid", out_valid, op_q.size() != 0);
      if (!out_valid) begin
        chk("idle_outs", ovec, 0);
        held = 0;
      end else if (op_q.size() != 0) begin
        op = op_q[0];
        model(op.x, op.y, op.s, beat, epp, ec, es, eo, et);
        chk("idx", out_idx, beat);
        chk("last", out_last, beat == NDIG - 1);
        chk("pp", out_pp, epp);
        chk("carry", out_carry, ec);
        chk("sign", out_sign, es);
        chk("one", out_one, eo);
        chk("two", out_two, et);
        if (held) chk("hold", ovec, saved);
        held  = !out_ready;
        saved = ovec;
        if (out_ready) begin
          acc = acc + ((longint'($signed(out_pp)) + longint'(out_carry)) << (2 * beat));
          if (beat == NDIG - 1) begin
            chk("identity", acc, prod(op));
            void'(op_q.pop_front());
            beat = 0;
            acc  = '0;
          end else begin
            beat++;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
    int c = 0;
    while (!in_ready) begin
      @(posedge clk);
      #1;
      if (++c > 500) begin
        timeout("send");
        return;
      end
    end
    in_x = x;
    in_y = y;
    in_signed = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idx(input int n);
    int c = 0;
    while (!(out_valid && out_idx == IDX_W'(n))) begin
      @(posedge clk);
      #1;
      if (++c > 100) begin
        timeout("wait_idx");
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (!(in_ready && !out_valid)) begin
      @(posedge clk);
      #1;
      if (++c > 500) begin
        timeout("wait_idle");
        return;
      end
    end
  endtask

  initial begin : main
    logic [33:0] pp;
    logic        c, sg, o, tw;
    logic [31:0] rx;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_signed = 1'b0;
    in_x = '0;
    in_y = '0;
    out_ready = 1'b1;

    // Hand-computed values pin the model itself.
    model(XD, 32'h1, 1'b0, 0, pp, c, sg, o, tw);
    chk("pin_y1_pp", pp, 34'h00000110F);
    chk("pin_y1_one", o, 1);
    model(XD, 32'h2, 1'b1, 0, pp, c, sg, o, tw);
    chk("pin_y2_pp", pp, 34'h3FFFFDDE1);
    chk("pin_y2_ctl", {c, sg, o, tw}, 4'b1101);
    model(XD, 32'h2, 1'b1, 1, pp, c, sg, o, tw);
    chk("pin_y2_b1", {pp, c, o}, {34'h00000110F, 1'b0, 1'b1});
    model(XD, 32'hFFFFFFFF, 1'b1, 0, pp, c, sg, o, tw);
    chk("pin_m1s_b0", {pp, c}, {34'h3FFFFEEF0, 1'b1});
    model(XD, 32'hFFFFFFFF, 1'b1, 9, pp, c, sg, o, tw);
    chk("pin_m1s_b9", {pp, c, sg}, {34'h0, 1'b0, 1'b1});
    model(XD, 32'hFFFFFFFF, 1'b0, 16, pp, c, sg, o, tw);
    chk("pin_m1u_b16", {pp, c, o}, {34'h00000110F, 1'b0, 1'b1});
    model(XD, 32'hFFFFFFFF, 1'b1, 16, pp, c, sg, o, tw);
    chk("pin_m1s_b16", {pp, c}, {34'h0, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(XD, 32'h0, 1'b1);
    send(XD, 32'h1, 1'b0);
    send(XD, 32'h2, 1'b1);
    send(XD, 32'h2, 1'b0);
    send(XD, 32'hFFFFFFFF, 1'b1);
    send(XD, 32'hFFFFFFFF, 1'b0);

    // Backpressure at idx 5 with ignored in_valid pulses.
    send(XD, 32'h12345678, 1'b1);
    wait_idx(5);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x = 32'hDEADBEEF;
    in_y = 32'hCAFEF00D;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Abort mid-operation, then a fresh op must start at idx 0.
    send(XD, 32'h87654321, 1'b0);
    wait_idx(7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(XD, 32'h5, 1'b1);
    wait_idle();

    fork
      begin
        while (!rnd_stop) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none

    for (int i = 0; i < NRAND; i++) begin
      case ($urandom_range(0, 7))
        0:       rx = 32'h80000000;
        1:       rx = 32'hFFFFFFFF;
        2:       rx = 32'h7FFFFFFF;
        default: rx = $urandom;
      endcase
      send(rx, (i % 11 == 0) ? 32'h80000000 : $urandom, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    rnd_stop = 1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
